// File: rtl/pret_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pret_pkg : shared types and sizing helper for the pret job controller
// Rev 1.0
// ---------------------------------------------------------------------------
package pret_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD     = 2'd1,
    RUN      = 2'd2,
    WAIT_OUT = 2'd3
  } pret_job_state_t;

  // Bz width: correlated streams share one W-bit word, otherwise one per input.
  function automatic int pret_tw(input int w, input int n, input int nc, input int corr);
    return (corr != 0) ? (w + nc) : (w * n + nc);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pret_job_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pret_job_ctrl_if : operand stream, pret side-band and result stream bundle
// Rev 1.0
// ---------------------------------------------------------------------------
interface pret_job_ctrl_if #(
  parameter int W  = 6,
  parameter int N  = 2,
  parameter int TW = 12,
  parameter int CW = 16
);

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_bxs   [N-1:0];
  logic [W-1:0]  pret_bxs [N-1:0];
  logic          pret_rst_n;
  logic          pret_done;
  logic [TW-1:0] pret_bz;
  logic          out_valid;
  logic          out_ready;
  logic [TW-1:0] out_bz;
  logic [CW-1:0] out_cycles;
  logic          out_timeout;

  modport slave (
    input  in_valid, in_bxs, pret_done, pret_bz, out_ready,
    output in_ready, pret_bxs, pret_rst_n, out_valid, out_bz, out_cycles, out_timeout
  );

  modport master (
    output in_valid, in_bxs, pret_done, pret_bz, out_ready,
    input  in_ready, pret_bxs, pret_rst_n, out_valid, out_bz, out_cycles, out_timeout
  );

endinterface
`default_nettype wire

// File: rtl/pret_op_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pret_op_fifo : synchronous operand FIFO, DEPTH (power of 2) entries
// Rev 1.0
// ---------------------------------------------------------------------------
module pret_op_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW:0]    r_wr;
  logic [c_AW:0]    r_rd;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign o_empty = (r_wr == r_rd);
  assign o_full  = (r_wr[c_AW] != r_rd[c_AW]) && (r_wr[c_AW-1:0] == r_rd[c_AW-1:0]);
  assign o_data  = r_mem[r_rd[c_AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr[c_AW-1:0]] <= i_data;
  end

endmodule
`default_nettype wire

// File: rtl/pret_job_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pret_job_ctrl : queues operand sets, sequences pret runs, returns Bz + cycles
// Optional run timeout: define PRET_TIMEOUT_EN.               Rev 1.0
// ---------------------------------------------------------------------------
module pret_job_ctrl
  import pret_pkg::*;
#(
  parameter int W     = 6,
  parameter int N     = 2,
  parameter int NC    = 0,
  parameter int CORR  = 0,
  parameter int TW    = pret_tw(W, N, NC, CORR),
  parameter int DEPTH = 4,
  parameter int CW    = 16
`ifdef PRET_TIMEOUT_EN
  ,
  parameter int MAX_CYC = 1 << TW
`endif
) (
  input  logic           clk,
  input  logic           rst_n,
  pret_job_ctrl_if.slave bus
);

  localparam int c_BW = W * N;

  pret_job_state_t r_state;
  pret_job_state_t w_state_nx;

  logic [c_BW-1:0] w_push_data;
  logic [c_BW-1:0] w_fifo_q;
  logic [c_BW-1:0] r_bxs;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_capture;
  logic            w_free;
  logic            w_end;
  logic            r_in_en;
  logic            r_pret_rst_n;
  logic            r_out_valid;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_inc;
  logic [CW-1:0]   w_cap_cnt;
  logic [TW-1:0]   r_out_bz;
  logic [CW-1:0]   r_out_cycles;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_bxs
      assign w_push_data[gi*W +: W] = bus.in_bxs[gi];
      assign bus.pret_bxs[gi]       = r_bxs[gi*W +: W];
    end
  endgenerate

  assign w_push = bus.in_valid && bus.in_ready;

  pret_op_fifo #(
    .WIDTH (c_BW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (w_fifo_q),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
  // In RUN the count includes the current (done) cycle; WAIT_OUT replays the stored count.
  assign w_cap_cnt = (r_state == RUN) ? w_cnt_inc : r_cnt;
  assign w_free    = !r_out_valid || bus.out_ready;

`ifdef PRET_TIMEOUT_EN
  localparam logic [CW:0] c_MAX_CYC = (CW+1)'(MAX_CYC);

  logic w_tmo;
  logic w_cap_to;
  logic r_to_pend;
  logic r_out_to;

  // A done in the same cycle wins over the timeout.
  assign w_tmo    = ({1'b0, w_cnt_inc} >= c_MAX_CYC) && !bus.pret_done;
  assign w_end    = bus.pret_done || w_tmo;
  assign w_cap_to = (r_state == RUN) ? w_tmo : r_to_pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_pend <= 1'b0;
      r_out_to  <= 1'b0;
    end else begin
      if ((r_state == RUN) && w_end) r_to_pend <= w_tmo;
      if (w_capture)                 r_out_to  <= w_cap_to;
    end
  end

  assign bus.out_timeout = r_out_to;
`else
  assign w_end           = bus.pret_done;
  assign bus.out_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_pop      = 1'b0;
    w_capture  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop      = 1'b1;
          w_state_nx = LOAD;
        end
      end
      LOAD: w_state_nx = RUN;
      RUN: begin
        if (w_end) begin
          if (w_free) begin
            w_capture  = 1'b1;
            w_pop      = !w_empty;
            w_state_nx = w_empty ? IDLE : LOAD;
          end else begin
            w_state_nx = WAIT_OUT;
          end
        end
      end
      WAIT_OUT: begin
        if (bus.out_ready) begin
          w_capture  = 1'b1;
          w_pop      = !w_empty;
          w_state_nx = w_empty ? IDLE : LOAD;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_en      <= 1'b0;
      r_bxs        <= '0;
      r_pret_rst_n <= 1'b0;
      r_cnt        <= '0;
      r_out_valid  <= 1'b0;
      r_out_bz     <= '0;
      r_out_cycles <= '0;
    end else begin
      r_in_en      <= 1'b1;
      // pret stays out of reset through WAIT_OUT so its Bz holds until captured.
      r_pret_rst_n <= (w_state_nx == RUN) || (w_state_nx == WAIT_OUT);
      if (w_pop) r_bxs <= w_fifo_q;
      if (r_state == LOAD)     r_cnt <= '0;
      else if (r_state == RUN) r_cnt <= w_cnt_inc;
      if (w_capture) begin
        r_out_valid  <= 1'b1;
        r_out_bz     <= bus.pret_bz;
        r_out_cycles <= w_cap_cnt;
      end else if (bus.out_ready) begin
        r_out_valid  <= 1'b0;
      end
    end
  end

  assign bus.in_ready   = r_in_en && !w_full;
  assign bus.pret_rst_n = r_pret_rst_n;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_bz     = r_out_bz;
  assign bus.out_cycles = r_out_cycles;

endmodule
`default_nettype wire
